// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the hardwired control sequencer:
//   - opcode values (IR[31:27])
//   - sequencer state encoding (T0..T7 share their step index in bits [2:0])
//   - instruction classes produced by op_decode
//   - ALU function codes and the control-strobe bundle
//   - ctl_decode(): Moore strobe pattern for a given state/class/opcode
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

   localparam int OP_W_DEF = 5;

   // Opcodes
   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_BR   = 5'b10010;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   // ALU function codes; R-type steps pass the opcode straight through
   localparam logic [4:0] ALU_NONE = 5'b00000;
   localparam logic [4:0] ALU_ADD  = OP_ADD;
   localparam logic [4:0] ALU_SUB  = OP_SUB;
   localparam logic [4:0] ALU_AND  = OP_AND;
   localparam logic [4:0] ALU_OR   = OP_OR;

   // T-states are numbered so that state[2:0] is the step index
   typedef enum logic [3:0] {
      S_T0    = 4'd0,
      S_T1    = 4'd1,
      S_T2    = 4'd2,
      S_T3    = 4'd3,
      S_T4    = 4'd4,
      S_T5    = 4'd5,
      S_T6    = 4'd6,
      S_T7    = 4'd7,
      S_RESET = 4'd8,
      S_HALT  = 4'd9
   } state_e;

   typedef enum logic [3:0] {
      CLS_LD   = 4'd0,
      CLS_LDI  = 4'd1,
      CLS_ST   = 4'd2,
      CLS_ALU  = 4'd3,
      CLS_ADDI = 4'd4,
      CLS_BR   = 4'd5,
      CLS_NOP  = 4'd6,
      CLS_HALT = 4'd7,
      CLS_ILL  = 4'd8
   } iclass_e;

   typedef struct packed {
      logic       pcout;
      logic       zhiout;
      logic       zlowout;
      logic       mdrout;
      logic       inportout;
      logic       marin;
      logic       zin;
      logic       pcin;
      logic       mdrin;
      logic       irin;
      logic       yin;
      logic       outportin;
      logic       incpc;
      logic       read;
      logic       write;
      logic       gra;
      logic       grb;
      logic       grc;
      logic       rin;
      logic       rout;
      logic       baout;
      logic       cout;
      logic       conin;
      logic       add;
      logic [4:0] aluop;
   } ctl_t;

   localparam ctl_t CTL_IDLE = ctl_t'(29'd0);

   // Strobe pattern for a state. The br T6 PCin is not produced here: it is
   // gated by BranchMet outside the register stage.
   function automatic ctl_t ctl_decode(input state_e st, input iclass_e cls,
                                       input logic [4:0] op);
      ctl_t c;
      c = CTL_IDLE;
      c.aluop = ALU_NONE;
      case (st)
         S_T0: begin
            c.pcout = 1'b1; c.marin = 1'b1; c.incpc = 1'b1; c.zin = 1'b1;
         end
         S_T1: begin
            c.zlowout = 1'b1; c.pcin = 1'b1; c.read = 1'b1; c.mdrin = 1'b1;
         end
         S_T2: begin
            c.mdrout = 1'b1; c.irin = 1'b1;
         end
         S_T3: begin
            case (cls)
               CLS_LD, CLS_LDI, CLS_ST: begin
                  c.grb = 1'b1; c.baout = 1'b1; c.yin = 1'b1;
               end
               CLS_ALU, CLS_ADDI: begin
                  c.grb = 1'b1; c.rout = 1'b1; c.yin = 1'b1;
               end
               CLS_BR: begin
                  c.gra = 1'b1; c.rout = 1'b1; c.conin = 1'b1;
               end
               default: c = CTL_IDLE;
            endcase
         end
         S_T4: begin
            case (cls)
               CLS_LD, CLS_LDI, CLS_ST, CLS_ADDI: begin
                  c.cout = 1'b1; c.add = 1'b1; c.zin = 1'b1;
               end
               CLS_ALU: begin
                  c.grc = 1'b1; c.rout = 1'b1; c.zin = 1'b1; c.aluop = op;
               end
               CLS_BR: begin
                  c.pcout = 1'b1; c.yin = 1'b1;
               end
               default: c = CTL_IDLE;
            endcase
         end
         S_T5: begin
            case (cls)
               CLS_LD, CLS_ST: begin
                  c.zlowout = 1'b1; c.marin = 1'b1;
               end
               CLS_LDI, CLS_ALU, CLS_ADDI: begin
                  c.zlowout = 1'b1; c.gra = 1'b1; c.rin = 1'b1;
               end
               CLS_BR: begin
                  c.cout = 1'b1; c.add = 1'b1; c.zin = 1'b1;
               end
               default: c = CTL_IDLE;
            endcase
         end
         S_T6: begin
            case (cls)
               CLS_LD: begin
                  c.read = 1'b1; c.mdrin = 1'b1;
               end
               CLS_ST: begin
                  c.gra = 1'b1; c.rout = 1'b1; c.mdrin = 1'b1;
               end
               CLS_BR: begin
                  c.zlowout = 1'b1;
               end
               default: c = CTL_IDLE;
            endcase
         end
         S_T7: begin
            case (cls)
               CLS_LD: begin
                  c.mdrout = 1'b1; c.gra = 1'b1; c.rin = 1'b1;
               end
               CLS_ST: begin
                  c.write = 1'b1;
               end
               default: c = CTL_IDLE;
            endcase
         end
         default: c = CTL_IDLE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/op_decode.sv
// -----------------------------------------------------------------------------
// op_decode
// Combinational opcode classifier.
//   i_opcode    : instruction opcode (IR[31:31-OP_W+1])
//   o_class     : instruction class
//   o_last_step : index of the final T-step of the instruction (fetch ends at 2)
// -----------------------------------------------------------------------------
module op_decode
   import cpu_ctrl_pkg::*;
#(
   parameter int OP_W = OP_W_DEF
) (
   input  logic [OP_W-1:0] i_opcode,
   output iclass_e         o_class,
   output logic [2:0]      o_last_step
);

   // Opcode to class and final step lookup
   always_comb begin
      o_class     = CLS_ILL;
      o_last_step = 3'd2;
      case (i_opcode)
         OP_W'(OP_LD):   begin o_class = CLS_LD;   o_last_step = 3'd7; end
         OP_W'(OP_LDI):  begin o_class = CLS_LDI;  o_last_step = 3'd5; end
         OP_W'(OP_ST):   begin o_class = CLS_ST;   o_last_step = 3'd7; end
         OP_W'(ALU_ADD),
         OP_W'(ALU_SUB),
         OP_W'(ALU_AND),
         OP_W'(ALU_OR):  begin o_class = CLS_ALU;  o_last_step = 3'd5; end
         OP_W'(OP_ADDI): begin o_class = CLS_ADDI; o_last_step = 3'd5; end
         OP_W'(OP_BR):   begin o_class = CLS_BR;   o_last_step = 3'd6; end
         OP_W'(OP_NOP):  begin o_class = CLS_NOP;  o_last_step = 3'd2; end
         OP_W'(OP_HALT): begin o_class = CLS_HALT; o_last_step = 3'd2; end
         default:        begin o_class = CLS_ILL;  o_last_step = 3'd2; end
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
// Hardwired Moore sequencer for the bus-based datapath: fetch (T0..T2), then
// the execute steps of the latched opcode, then T0 again or HALT.
//   Clock, Clear(async, active low)   : clock and reset
//   IR, BranchMet, Stop               : instruction, CON flag, halt request
//   bus drives  : PCout Zhiout Zlowout MDRout InPortout
//   reg loads   : MARin Zin PCin MDRin IRin Yin OutPortin
//   memory/PC   : IncPC Read Write
//   reg file    : Gra Grb Grc Rin Rout BAout Cout CONIn
//   ALU         : ADD AluOp
//   status      : Run (sequencing), Illegal (undefined opcode pulse)
// All strobes are registered for the state being entered, so they change only
// at the clock edge. The one exception is PCin in br T6, which is qualified
// by BranchMet combinationally.
// -----------------------------------------------------------------------------
module control_unit
   import cpu_ctrl_pkg::*;
#(
   parameter int OP_W = OP_W_DEF
) (
   input  logic        Clock,
   input  logic        Clear,
   input  logic [31:0] IR,
   input  logic        BranchMet,
   input  logic        Stop,
   output logic        PCout,
   output logic        Zhiout,
   output logic        Zlowout,
   output logic        MDRout,
   output logic        InPortout,
   output logic        MARin,
   output logic        Zin,
   output logic        PCin,
   output logic        MDRin,
   output logic        IRin,
   output logic        Yin,
   output logic        OutPortin,
   output logic        IncPC,
   output logic        Read,
   output logic        Write,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic        Cout,
   output logic        CONIn,
   output logic        ADD,
   output logic [4:0]  AluOp,
   output logic        Run,
   output logic        Illegal
);

   state_e          r_state;
   state_e          w_next_state;
   logic [OP_W-1:0] r_opcode;
   logic [OP_W-1:0] w_ir_op;
   logic [OP_W-1:0] w_cur_op;
   iclass_e         w_class;
   logic [2:0]      w_last_step;
   logic            r_stop;
   logic            w_stop;
   ctl_t            r_ctl;
   ctl_t            w_next_ctl;
   logic            r_run;
   logic            r_illegal;
   logic            r_br_t6;
   logic            w_unused_ir;

   assign w_ir_op     = IR[31 -: OP_W];
   assign w_unused_ir = ^IR[31-OP_W:0];

   // In T2 the new IR is already valid, so decode it directly; afterwards
   // the latched copy is used.
   assign w_cur_op = (r_state == S_T2) ? w_ir_op : r_opcode;

   op_decode #(.OP_W(OP_W)) u_op_decode (
      .i_opcode    (w_cur_op),
      .o_class     (w_class),
      .o_last_step (w_last_step)
   );

   // Next-state selection and sticky stop request
   always_comb begin
      w_next_state = r_state;
      w_stop       = r_stop | Stop;
      case (r_state)
         S_RESET: w_next_state = S_T0;
         S_HALT:  w_next_state = S_HALT;
         S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7: begin
            if (r_state[2:0] >= w_last_step) begin
               if ((w_class == CLS_HALT) || w_stop) begin
                  w_next_state = S_HALT;
               end else begin
                  w_next_state = S_T0;
               end
            end else begin
               w_next_state = state_e'(r_state + 4'd1);
            end
         end
         default: w_next_state = S_RESET;
      endcase
   end

   // Strobes for the state about to be entered
   always_comb begin
      w_next_ctl = ctl_decode(w_next_state, w_class, 5'(w_cur_op));
   end

   // Sequencer state, opcode latch and registered outputs
   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         r_state   <= S_RESET;
         r_opcode  <= {OP_W{1'b0}};
         r_stop    <= 1'b0;
         r_ctl     <= CTL_IDLE;
         r_run     <= 1'b0;
         r_illegal <= 1'b0;
         r_br_t6   <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_stop  <= w_stop;
         if (r_state == S_T2) begin
            r_opcode <= w_ir_op;
         end else begin
            r_opcode <= r_opcode;
         end
         r_ctl     <= w_next_ctl;
         r_run     <= (w_next_state != S_RESET) && (w_next_state != S_HALT);
         r_illegal <= (r_state == S_T2) && (w_class == CLS_ILL);
         r_br_t6   <= (w_next_state == S_T6) && (w_class == CLS_BR);
      end
   end

   assign PCout     = r_ctl.pcout;
   assign Zhiout    = r_ctl.zhiout;
   assign Zlowout   = r_ctl.zlowout;
   assign MDRout    = r_ctl.mdrout;
   assign InPortout = r_ctl.inportout;
   assign MARin     = r_ctl.marin;
   assign Zin       = r_ctl.zin;
   assign PCin      = r_ctl.pcin | (r_br_t6 & BranchMet);
   assign MDRin     = r_ctl.mdrin;
   assign IRin      = r_ctl.irin;
   assign Yin       = r_ctl.yin;
   assign OutPortin = r_ctl.outportin;
   assign IncPC     = r_ctl.incpc;
   assign Read      = r_ctl.read;
   assign Write     = r_ctl.write;
   assign Gra       = r_ctl.gra;
   assign Grb       = r_ctl.grb;
   assign Grc       = r_ctl.grc;
   assign Rin       = r_ctl.rin;
   assign Rout      = r_ctl.rout;
   assign BAout     = r_ctl.baout;
   assign Cout      = r_ctl.cout;
   assign CONIn     = r_ctl.conin;
   assign ADD       = r_ctl.add;
   assign AluOp     = r_ctl.aluop;
   assign Run       = r_run;
   assign Illegal   = r_illegal;

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
// Scoreboard bench: each issued instruction pushes its expected per-cycle
// output vector; a negedge monitor pops and compares against the DUT.
// -----------------------------------------------------------------------------
module tb_control_unit;

   localparam logic [4:0] T_LD = 5'b00000, T_LDI = 5'b00001, T_ST = 5'b00010;
   localparam logic [4:0] T_ADD = 5'b00011, T_SUB = 5'b00100;
   localparam logic [4:0] T_AND = 5'b00101, T_OR = 5'b00110;
   localparam logic [4:0] T_ADDI = 5'b01100, T_BR = 5'b10010;
   localparam logic [4:0] T_NOP = 5'b11010, T_HALT = 5'b11011;

   localparam logic [31:0] M_ILL   = 32'd1 << 5;
   localparam logic [31:0] M_RUN   = 32'd1 << 6;
   localparam logic [31:0] M_ADD   = 32'd1 << 7;
   localparam logic [31:0] M_CONIN = 32'd1 << 8;
   localparam logic [31:0] M_COUT  = 32'd1 << 9;
   localparam logic [31:0] M_BAOUT = 32'd1 << 10;
   localparam logic [31:0] M_ROUT  = 32'd1 << 11;
   localparam logic [31:0] M_RIN   = 32'd1 << 12;
   localparam logic [31:0] M_GRC   = 32'd1 << 13;
   localparam logic [31:0] M_GRB   = 32'd1 << 14;
   localparam logic [31:0] M_GRA   = 32'd1 << 15;
   localparam logic [31:0] M_WRITE = 32'd1 << 16;
   localparam logic [31:0] M_READ  = 32'd1 << 17;
   localparam logic [31:0] M_INCPC = 32'd1 << 18;
   localparam logic [31:0] M_YIN   = 32'd1 << 20;
   localparam logic [31:0] M_IRIN  = 32'd1 << 21;
   localparam logic [31:0] M_MDRIN = 32'd1 << 22;
   localparam logic [31:0] M_PCIN  = 32'd1 << 23;
   localparam logic [31:0] M_ZIN   = 32'd1 << 24;
   localparam logic [31:0] M_MARIN = 32'd1 << 25;
   localparam logic [31:0] M_MDROUT= 32'd1 << 27;
   localparam logic [31:0] M_ZLOW  = 32'd1 << 28;
   localparam logic [31:0] M_PCOUT = 32'd1 << 30;

   logic        Clock, Clear, BranchMet, Stop;
   logic [31:0] IR;
   logic PCout, Zhiout, Zlowout, MDRout, InPortout, MARin, Zin, PCin, MDRin;
   logic IRin, Yin, OutPortin, IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout;
   logic BAout, Cout, CONIn, ADD, Run, Illegal;
   logic [4:0]  AluOp;
   logic [31:0] w_obs;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sb_entry_t;

   sb_entry_t   sb[$];
   sb_entry_t   sb_e;
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] pend_ill = 32'd0;

   control_unit dut (
      .Clock(Clock), .Clear(Clear), .IR(IR), .BranchMet(BranchMet), .Stop(Stop),
      .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout), .MDRout(MDRout),
      .InPortout(InPortout), .MARin(MARin), .Zin(Zin), .PCin(PCin),
      .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .OutPortin(OutPortin),
      .IncPC(IncPC), .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb),
      .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
      .CONIn(CONIn), .ADD(ADD), .AluOp(AluOp), .Run(Run), .Illegal(Illegal)
   );

   assign w_obs = {1'b0, PCout, Zhiout, Zlowout, MDRout, InPortout, MARin, Zin,
                   PCin, MDRin, IRin, Yin, OutPortin, IncPC, Read, Write, Gra,
                   Grb, Grc, Rin, Rout, BAout, Cout, CONIn, ADD, Run, Illegal,
                   AluOp};

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Monitor: one scoreboard entry per cycle, sampled mid-cycle
   always @(negedge Clock) begin
      if (sb.size() > 0) begin
         sb_e = sb.pop_front();
         check(sb_e.tag, w_obs, sb_e.exp);
      end
   end

   function automatic int lat(input logic [4:0] op);
      case (op)
         T_LD, T_ST: return 8;
         T_LDI, T_ADD, T_SUB, T_AND, T_OR, T_ADDI: return 6;
         T_BR: return 7;
         default: return 3;
      endcase
   endfunction

   function automatic bit defined_op(input logic [4:0] op);
      case (op)
         T_LD, T_LDI, T_ST, T_ADD, T_SUB, T_AND, T_OR, T_ADDI, T_BR,
         T_NOP, T_HALT: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Reference strobe pattern for step s of opcode op
   function automatic logic [31:0] exp_vec(input logic [4:0] op, input int s,
                                           input logic bm);
      logic [31:0] v;
      v = M_RUN;
      if (s == 0)      v |= M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
      else if (s == 1) v |= M_ZLOW | M_PCIN | M_READ | M_MDRIN;
      else if (s == 2) v |= M_MDROUT | M_IRIN;
      else if (op == T_LD || op == T_LDI || op == T_ST) begin
         case (s)
            3: v |= M_GRB | M_BAOUT | M_YIN;
            4: v |= M_COUT | M_ADD | M_ZIN;
            5: v |= (op == T_LDI) ? (M_ZLOW | M_GRA | M_RIN) : (M_ZLOW | M_MARIN);
            6: v |= (op == T_LD) ? (M_READ | M_MDRIN) : (M_GRA | M_ROUT | M_MDRIN);
            default: v |= (op == T_LD) ? (M_MDROUT | M_GRA | M_RIN) : M_WRITE;
         endcase
      end else if (op == T_ADD || op == T_SUB || op == T_AND || op == T_OR) begin
         case (s)
            3: v |= M_GRB | M_ROUT | M_YIN;
            4: v |= M_GRC | M_ROUT | M_ZIN | {27'd0, op};
            default: v |= M_ZLOW | M_GRA | M_RIN;
         endcase
      end else if (op == T_ADDI) begin
         case (s)
            3: v |= M_GRB | M_ROUT | M_YIN;
            4: v |= M_COUT | M_ADD | M_ZIN;
            default: v |= M_ZLOW | M_GRA | M_RIN;
         endcase
      end else begin
         case (s)
            3: v |= M_GRA | M_ROUT | M_CONIN;
            4: v |= M_PCOUT | M_YIN;
            5: v |= M_COUT | M_ADD | M_ZIN;
            default: v |= M_ZLOW | (bm ? M_PCIN : 32'd0);
         endcase
      end
      return v;
   endfunction

   task automatic push_exp(input string tag, input logic [31:0] v);
      sb_entry_t e;
      e.tag = tag;
      e.exp = v;
      sb.push_back(e);
   endtask

   task automatic push_steps(input logic [4:0] op, input logic bm,
                             input int s0, input int s1);
      logic [31:0] v;
      for (int s = s0; s <= s1; s++) begin
         v = exp_vec(op, s, bm);
         if (s == 0) begin
            v |= pend_ill;
            pend_ill = 32'd0;
         end
         push_exp($sformatf("op%b_bm%0d_T%0d", op, bm, s), v);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   // Drive one instruction starting in T0 and expect its full sequence
   task automatic issue(input logic [31:0] ir, input logic bm);
      logic [4:0] op;
      int         n;
      op        = ir[31:27];
      n         = lat(op);
      IR        = ir;
      BranchMet = bm;
      push_steps(op, bm, 0, n - 1);
      pend_ill  = defined_op(op) ? 32'd0 : M_ILL;
      wait_cyc(n);
   endtask

   initial begin
      IR = 32'd0; BranchMet = 1'b0; Stop = 1'b0;
      Clear = 1'b1;
      #1 Clear = 1'b0;
      wait_cyc(1);
      push_exp("reset0", 32'd0);
      push_exp("reset1", 32'd0);
      wait_cyc(2);
      Clear = 1'b1;
      push_exp("reset_rel", 32'd0);
      wait_cyc(1);

      issue(32'h0080_0055, 1'b0);   // ld
      issue(32'h0900_0007, 1'b0);   // ldi
      issue(32'h1000_0000, 1'b0);   // st
      issue(32'h1800_0000, 1'b0);   // add
      issue(32'h2000_0000, 1'b0);   // sub
      issue(32'h2800_0000, 1'b0);   // and
      issue(32'h3000_0000, 1'b0);   // or
      issue(32'h6000_0000, 1'b0);   // addi
      issue(32'h9000_0000, 1'b1);   // br taken
      issue(32'h9000_0000, 1'b0);   // br not taken
      issue(32'hD000_0000, 1'b0);   // nop
      issue(32'hF800_0000, 1'b0);   // undefined 11111
      issue(32'h0900_0001, 1'b0);   // ldi: T0 carries the Illegal pulse

      // Clear dropped in T6 of st: outputs clear without waiting for an edge
      IR = 32'h1000_0000;
      push_steps(T_ST, 1'b0, 0, 5);
      wait_cyc(6);
      Clear = 1'b0;
      push_exp("st_clr_low", 32'd0);
      #1 check("st_clr_async", w_obs, 32'd0);
      wait_cyc(1);
      Clear = 1'b1;
      push_exp("st_clr_rel", 32'd0);
      wait_cyc(1);
      issue(32'h0080_0055, 1'b0);   // ld after release starts at T0

      // halt: Run and all strobes low for 20 cycles
      issue(32'hD800_0000, 1'b0);
      for (int i = 0; i < 20; i++) push_exp($sformatf("halt_%0d", i), 32'd0);
      wait_cyc(20);
      Clear = 1'b0;
      push_exp("halt_clr", 32'd0);
      wait_cyc(1);
      Clear = 1'b1;
      push_exp("halt_rel", 32'd0);
      wait_cyc(1);

      // Stop pulsed during T4 of add: T5 still runs, then HALT
      IR = 32'h1800_0000;
      push_steps(T_ADD, 1'b0, 0, 5);
      wait_cyc(4);
      Stop = 1'b1;
      wait_cyc(1);
      Stop = 1'b0;
      wait_cyc(1);
      for (int i = 0; i < 3; i++) push_exp($sformatf("stop_halt_%0d", i), 32'd0);
      wait_cyc(3);

      check("sb_drain", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired Moore control sequencer for the 32-bit bus-based datapath. It sits directly upstream of `Datapath_P2` and drives every datapath control strobe. The datapath testbenches currently drive these strobes by hand. The block fetches an instruction, decodes `IR[31:27]`, and steps T0..T7 through the micro-operations for loads, stores, ALU operations, branches, `nop` and `halt`.

## Interface
- `OP_W`, default 5: opcode width, taken from `IR[31:31-OP_W+1]`.
- `Clock` in 1: single system clock; all state changes occur on the rising edge.
- `Clear` in 1: asynchronous, active-low reset.
- `IR` in 32: instruction register contents from the datapath.
- `BranchMet` in 1: CON flip-flop output from the datapath.
- `Stop` in 1: level request to halt after the current instruction.
- `PCout`, `Zhiout`, `Zlowout`, `MDRout`, `InPortout` out 1 each: bus drive enables.
- `MARin`, `Zin`, `PCin`, `MDRin`, `IRin`, `Yin`, `OutPortin` out 1 each: register load enables.
- `IncPC`, `Read`, `Write` out 1 each: PC increment and memory strobes. `Read` selects memory into MDR; otherwise MDR loads from the bus.
- `Gra`, `Grb`, `Grc`, `Rin`, `Rout`, `BAout`, `Cout`, `CONIn` out 1 each: register-select, register-file and immediate control.
- `ADD` out 1: forces the ALU to add, used for address and immediate steps.
- `AluOp` out 5: ALU function. Equals the opcode during the R-type T4 step, 0 otherwise.
- `Run` out 1: 1 while sequencing, 0 in HALT.
- `Illegal` out 1: one-cycle pulse when an undefined opcode is decoded.

## Operation
- Opcodes:
  - `ld` 00000, `ldi` 00001, `st` 00010.
  - `add` 00011, `sub` 00100, `and` 00101, `or` 00110.
  - `addi` 01100, `br` 10010.
  - `nop` 11010, `halt` 11011.
- Fetch, common to all instructions:
  - T0: `PCout`, `MARin`, `IncPC`, `Zin`.
  - T1: `Zlowout`, `PCin`, `Read`, `MDRin`.
  - T2: `MDRout`, `IRin`.
- `ld`:
  - T3 `Grb`, `BAout`, `Yin`.
  - T4 `Cout`, `ADD`, `Zin`.
  - T5 `Zlowout`, `MARin`.
  - T6 `Read`, `MDRin`.
  - T7 `MDRout`, `Gra`, `Rin`.
- `ldi`: T3 and T4 as `ld`; T5 `Zlowout`, `Gra`, `Rin`.
- `st`:
  - T3–T5 as `ld`.
  - T6 `Gra`, `Rout`, `MDRin` (with `Read`=0).
  - T7 `Write`.
- R-type (`add`/`sub`/`and`/`or`):
  - T3 `Grb`, `Rout`, `Yin`.
  - T4 `Grc`, `Rout`, `AluOp`=opcode, `Zin`.
  - T5 `Zlowout`, `Gra`, `Rin`.
- `addi`:
  - T3 `Grb`, `Rout`, `Yin`.
  - T4 `Cout`, `ADD`, `Zin`.
  - T5 `Zlowout`, `Gra`, `Rin`.
- `br`:
  - T3 `Gra`, `Rout`, `CONIn`.
  - T4 `PCout`, `Yin`.
  - T5 `Cout`, `ADD`, `Zin`.
  - T6 `Zlowout`; `PCin` only if `BranchMet`=1 during T6.
- `nop` and undefined opcodes:
  - After T2, go to T0 with no execute steps.
  - An undefined opcode pulses `Illegal` in the cycle after T2.
- `halt`: after T2, enter HALT. HALT asserts all strobes 0 and `Run`=0. Only `Clear` exits HALT.
- `Stop`:
  - Sampled every cycle into a sticky flag.
  - At the last step of any instruction, the flag selects HALT instead of T0.
  - `Stop` never aborts an instruction mid-sequence.
- States: RESET, T0..T7, HALT.
  - RESET is entered asynchronously while `Clear`=0.
  - RESET goes to T0 on the first rising edge with `Clear`=1.

## Timing
- Every step lasts exactly one clock.
- Outputs decode only from the state register and the latched opcode. They are glitch-free relative to the `Clock` edge, and the datapath samples them at the next rising edge.
- The opcode is latched from `IR` on the edge leaving T2, so the datapath's new `IR` value is seen.
- Instruction latency in clocks:
  - `ld` 8, `ldi` 6, `st` 8.
  - R-type 6, `addi` 6, `br` 7.
  - `nop` 3.
- Reset values:
  - While `Clear`=0, every output is 0, including `Run`=0 and `Illegal`=0.
  - `Run` goes to 1 in T0.
- Reset mid-operation: outputs drop immediately, asynchronously. No partial `Write` may persist. The next instruction begins at T0.
- `BranchMet` is sampled combinationally only in T6 of `br`.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - opcode localparams;
  - state encoding for RESET, T0–T7 and HALT;
  - `AluOp` constants.
- Sub-module `op_decode`: combinational opcode → instruction class plus last-step index. It is shared with later pipeline work.

## Test plan
- `IR`=0x00800055 (`ld` R1, 0x55(R0)) after reset → T0–T7 strobe sequence exactly as listed; `Rin` and `Gra` high only in T7; then returns to T0.
- `IR`=0x09000007 (`ldi`) → `Cout`/`ADD`/`Zin` in T4; `Zlowout`/`Gra`/`Rin` in T5; next cycle T0.
- `st` → `Write` high exactly one cycle, in T7; `Read` low in T6.
- `br` with `BranchMet`=1 → `PCin` high in T6. With `BranchMet`=0 → `PCin` low in T6 and the PC is not reloaded.
- Opcode 11111 → `Illegal` one-cycle pulse, then T0. `halt` → `Run`=0, all strobes 0 for 20 cycles. `Stop` pulsed in T4 of `add` → T5 completes, then HALT.
- `Clear` low in T6 of `st` → all outputs 0 before the next edge and no `Write`. After release, T0 follows on the first edge.
